// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative RV32M multiply/divide unit for the execute stage. One operation
//   is accepted from IDLE, runs XLEN shift-add (multiply) or restoring
//   shift-subtract (divide) iterations in RUN, and is sign-corrected and
//   presented in DONE. Divide-by-zero and signed overflow skip RUN entirely.
//
// Ports
//   clk     in   single clock, rising edge
//   reset   in   synchronous active-high reset
//   start   in   M-extension instruction valid in EX
//   flush   in   kill the requested / in-flight operation (beats start)
//   funct3  in   000 MUL 001 MULH 010 MULHSU 011 MULHU
//                100 DIV 101 DIVU 110 REM 111 REMU
//   srca    in   rs1: multiplicand / dividend
//   srcb    in   rs2: multiplier / divisor
//   stall   out  hold IF/ID/EX while the operation is outstanding
//   busy    out  FSM not in IDLE
//   valid   out  one-cycle result strobe (DONE)
//   result  out  result; the new value is visible during DONE and held after

module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic            stall,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_next;
  logic [2:0]          op;
  logic [XLEN-1:0]     operand;     // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0]   acc;         // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [CW-1:0]       cnt;
  logic                neg_main;    // sign of product / quotient
  logic                neg_rem;     // sign of remainder (dividend sign)
  logic                special;     // acc low half already holds the final value
  logic [XLEN-1:0]     result_q;

  // ---------------------------------------------------------------------------
  // Input decode: signedness, magnitudes, special cases
  // ---------------------------------------------------------------------------
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            accept, div_zero, div_ovf, special_in;
  logic [XLEN-1:0] special_val;

  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    unique case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'b010:  a_signed = 1'b1;
      default: ;
    endcase
  end

  assign a_neg  = a_signed & srca[XLEN-1];
  assign b_neg  = b_signed & srcb[XLEN-1];
  // The most negative value negates to itself, which read unsigned is the
  // correct magnitude.
  assign a_mag  = a_neg ? -srca : srca;
  assign b_mag  = b_neg ? -srcb : srcb;
  assign accept = (state == IDLE) & start & ~flush;

  assign div_zero   = funct3[2] & (srcb == '0);
  // a_signed among divide ops selects DIV/REM only.
  assign div_ovf    = funct3[2] & a_signed & (srca == {1'b1, {(XLEN-1){1'b0}}})
                    & (srcb == '1);
  assign special_in = div_zero | div_ovf;

  // funct3[1] distinguishes REM/REMU from DIV/DIVU. Overflow quotient is the
  // dividend itself (the most negative value).
  always_comb begin
    special_val = '0;
    if (div_zero) special_val = funct3[1] ? srca : '1;
    else          special_val = funct3[1] ? '0   : srca;
  end

  // ---------------------------------------------------------------------------
  // One iteration of each algorithm
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_sh;
  logic              borrow;
  logic [XLEN-1:0]   rem_sub;
  logic [2*XLEN-1:0] div_next;

  // Shift-add: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // Restoring division: shift the next dividend bit into the remainder, keep
  // the subtraction only if it does not go negative. When it is kept the
  // difference is below the divisor, so XLEN bits are exact.
  assign rem_sh   = acc[2*XLEN-1:XLEN-1];
  assign borrow   = rem_sh < {1'b0, operand};
  assign rem_sub  = rem_sh[XLEN-1:0] - operand;
  assign div_next = {(borrow ? rem_sh[XLEN-1:0] : rem_sub), acc[XLEN-2:0], ~borrow};

  // ---------------------------------------------------------------------------
  // Sign correction and result selection (used in DONE)
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, final_val;

  assign prod = neg_main ? -acc : acc;
  assign quo  = acc[XLEN-1:0];
  assign rem  = acc[2*XLEN-1:XLEN];

  always_comb begin
    final_val = '0;
    if (special) begin
      final_val = acc[XLEN-1:0];
    end else begin
      unique case (op)
        3'b000:                 final_val = prod[XLEN-1:0];
        3'b001, 3'b010, 3'b011: final_val = prod[2*XLEN-1:XLEN];
        3'b100, 3'b101:         final_val = neg_main ? -quo : quo;
        default:                final_val = neg_rem  ? -rem : rem;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = special_in ? DONE : RUN;
      RUN:     if (cnt == CW'(XLEN-1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op       <= '0;
      operand  <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      special  <= 1'b0;
      result_q <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: if (accept) begin
          op       <= funct3;
          cnt      <= '0;
          neg_main <= a_neg ^ b_neg;
          neg_rem  <= a_neg;
          special  <= special_in;
          operand  <= funct3[2] ? b_mag : a_mag;
          acc      <= {{XLEN{1'b0}},
                       special_in ? special_val : (funct3[2] ? a_mag : b_mag)};
        end
        RUN: begin
          acc <= op[2] ? div_next : mul_next;
          cnt <= cnt + 1'b1;
        end
        DONE:    if (!flush) result_q <= final_val;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign stall  = accept | ((state == RUN) & ~flush);
  assign busy   = (state != IDLE);
  assign valid  = (state == DONE) & ~flush;
  // The instruction leaves EX during DONE, so the corrected value is shown
  // combinationally there and captured for the following cycles.
  assign result = (state == DONE) ? final_val : result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//   Scoreboard bench for muldiv_unit. The driver pushes the expected result
//   when an operation is issued and checks stall/latency; an independent
//   monitor pops and compares on every valid. Expected values come from
//   directed constants or a 64-bit arithmetic reference model.

module tb_muldiv_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  logic            clk = 1'b0;
  logic            reset, start, flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] srca, srcb;
  logic            stall, busy, valid;
  logic [XLEN-1:0] result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] exp_q[$];

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .srca   (srca),
    .srcb   (srcb),
    .stall  (stall),
    .busy   (busy),
    .valid  (valid),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    case (f)
      3'b000: begin p = sa * sb; return p[31:0];  end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return MIN_INT;
        p = sa / sb; return p[31:0];
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'b100 || f == 3'b110) && a == MIN_INT && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // Monitor: compares every valid against the head of the scoreboard.
  always begin
    @(negedge clk);
    #2;
    if (!reset && valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        check("result", result, exp_q.pop_front());
      end
    end
  end

  // Issue one operation and wait for its valid; checks stall span and latency.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, output int vcyc);
    int t0, stall_cnt, lat;
    bit got;
    lat = exp_latency(f, a, b);
    @(negedge clk);
    start = 1'b1; funct3 = f; srca = a; srcb = b;
    exp_q.push_back(exp);
    #1;
    check("stall_on_start", 32'(stall), 32'd1);
    t0 = cyc;
    stall_cnt = 1;
    got = 1'b0;
    vcyc = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (valid) begin
        got  = 1'b1;
        vcyc = cyc;
        check("latency", 32'(cyc - t0), 32'(lat));
        check("stall_span", 32'(stall_cnt), 32'(lat));
        check("stall_in_done", 32'(stall), 32'd0);
        check("busy_in_done", 32'(busy), 32'd1);
      end else if (stall) begin
        stall_cnt++;
      end
    end
    if (!got) check("valid_timeout", 32'd0, 32'd1);
  endtask

  // Start an operation that will be aborted; returns during RUN with counter = 10.
  task automatic start_to_cnt10(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; funct3 = f; srca = a; srcb = b;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t dir[10] = '{
    '{3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD},
    '{3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF},
    '{3'b101, 32'h1234_5678, 32'd0,        32'hFFFF_FFFF},
    '{3'b111, 32'h1234_5678, 32'd0,        32'h1234_5678},
    '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
    '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
    '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000},
    '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
    '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE}
  };

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return MIN_INT;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int v1, v2;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    reset = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = '0; srca = '0; srcb = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy",   32'(busy),  32'd0);
    check("reset_valid",  32'(valid), 32'd0);
    check("reset_result", result,     32'd0);
    check("reset_stall",  32'(stall), 32'd0);
    reset = 1'b0;

    // Directed cases
    foreach (dir[i]) do_op(dir[i].f, dir[i].a, dir[i].b, dir[i].exp, v1);

    // Reset mid-RUN
    start_to_cnt10(3'b101, 32'd1000, 32'd3);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("midrun_reset_busy",   32'(busy),  32'd0);
    check("midrun_reset_valid",  32'(valid), 32'd0);
    check("midrun_reset_result", result,     32'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);

    // Flush mid-RUN
    start_to_cnt10(3'b101, 32'd1000, 32'd3);
    flush = 1'b1;
    #1;
    check("flush_stall_drop", 32'(stall), 32'd0);
    check("flush_no_valid",   32'(valid), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_idle_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    do_op(3'b101, 32'd100, 32'd7, 32'd14, v1);

    // start and flush together
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'b000; srca = 32'd3; srcb = 32'd5;
    #1;
    check("startflush_stall", 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check("startflush_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);

    // Back-to-back
    do_op(3'b000, 32'd3,   32'd5, 32'd15, v1);
    do_op(3'b111, 32'd100, 32'd7, 32'd2,  v2);
    check("b2b_gap", 32'(v2 - v1), 32'd34);
    repeat (40) @(negedge clk);

    // Randomized against the reference model
    for (int n = 0; n < 80; n++) begin
      rf = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      do_op(rf, ra, rb, model(rf, ra, rb), v1);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execute unit with its own sequencing FSM, sitting beside the ALU in the execute stage. It accepts one M-extension operation from the execute stage, runs a 32-iteration shift-add or shift-subtract sequence, and holds the pipeline with `stall` until the result is ready. The main/ALU decoders raise `start` for OP-class instructions (`op` = 0110011) with funct7 = 0000001.

## Interface
- `XLEN`, default 32: operand and result width. The iteration count equals `XLEN`.
- `clk`  in  1  system clock. This is the block's single clock; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request: the M-extension instruction is valid in the execute stage.
- `flush`  in  1  kills the in-flight or requested operation.
- `funct3`  in  3  operation select:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `srca`  in  XLEN  rs1 operand: multiplicand or dividend.
- `srcb`  in  XLEN  rs2 operand: multiplier or divisor.
- `stall`  out  1  freezes the IF/ID/EX pipeline registers.
- `busy`  out  1  high when the FSM is not IDLE.
- `valid`  out  1  one-cycle result strobe.
- `result`  out  XLEN  result register.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - On `start & !flush`, latch `funct3`, the operand magnitudes and the result sign, and clear the iteration counter.
  - Go to DONE directly for the special cases below. Otherwise go to RUN.
- **RUN**
  - Executes one iteration per cycle and increments the counter.
  - After the iteration with counter = XLEN-1, go to DONE.
- **DONE**
  - Apply the sign correction and write `result`.
  - `valid` = 1 for this cycle, then go to IDLE.
  - `start` is ignored in DONE.
- **Signedness**
  - Signed operands: MUL/MULH/DIV/REM use both operands signed. MULHSU uses srca signed and srcb unsigned. MULHU/DIVU/REMU use both unsigned.
  - Negative operands are converted to magnitude before the iterations.
  - Sign fixup: product sign = XOR of the operand signs. Quotient sign = XOR of the operand signs. Remainder sign = dividend sign.
- **Result selection**
  - Multiply builds a 2·XLEN-bit product. MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - Divide is restoring division and yields both the quotient and the remainder. DIV/DIVU return the quotient; REM/REMU return the remainder.
- **Special cases** (resolved in IDLE; no RUN cycles)
  - Divide by zero: quotient = all ones, remainder = dividend (unmodified).
  - Signed overflow (srca = 0x80000000, srcb = 0xFFFFFFFF for DIV/REM): quotient = 0x80000000, remainder = 0.
  - Multiply has no special cases.
- **`stall`** = (IDLE & start & !flush) | RUN. `stall` is 0 in DONE, so the instruction leaves EX carrying `result`.
- **`flush`**
  - Has priority over `start` in the same cycle.
  - In any state, the next state is IDLE, no `valid` is raised, and `stall` drops combinationally.
  - `result` keeps its previous value.
- **`result`**
  - Holds its value until the next DONE.
  - `valid` is the only qualifier.

## Timing
- **Reset:** state = IDLE; `busy` = 0, `valid` = 0, `result` = 0, counter = 0. A reset mid-RUN aborts the operation with no `valid`.
- **Normal latency:** start sampled at edge k → RUN during cycles k+1 … k+32 → DONE (`valid` = 1) during cycle k+33.
- **Special-case latency:** DONE during cycle k+1.
- **`stall`:** high from the cycle `start` is presented through the last RUN cycle.
- **`busy`:** high from the cycle after `start` is sampled through DONE.
- **Back-to-back:** after DONE the FSM is in IDLE, and a new `start` is accepted in the next cycle.

## Test plan
- **Reset and idle:** apply reset mid-RUN (counter = 10) → next cycle IDLE, `busy` = 0, `valid` = 0, `result` = 0.
- **Signed divide:**
  - DIV −7 / 2 → `result` = 0xFFFFFFFD.
  - REM −7 / 2 → `result` = 0xFFFFFFFF.
  - Both `valid` exactly 33 cycles after `start` is sampled; `stall` high for the 33 preceding cycles.
- **Divide special cases:**
  - DIVU 0x12345678 / 0 → `result` = 0xFFFFFFFF.
  - REMU 0x12345678 / 0 → `result` = 0x12345678.
  - DIV 0x80000000 / 0xFFFFFFFF → `result` = 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → `result` = 0.
  - All four: `valid` one cycle after `start`.
- **Multiply:**
  - MUL 0x80000000 × 0x80000000 → `result` = 0.
  - MULH 0x80000000 × 0x80000000 → `result` = 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → `result` = 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → `result` = 0xFFFFFFFE.
- **Flush:**
  - `flush` at RUN counter = 10 → `stall` = 0 in the same cycle, IDLE next cycle, no `valid`.
  - A new DIVU 100 / 7 then gives `result` = 14 after 33 cycles.
  - `start` and `flush` in the same cycle → not accepted.
- **Back-to-back:** MUL 3 × 5 then REMU 100 / 7 in consecutive EX slots → `valid` with 15, then `valid` with 2, 34 cycles apart. Neither `valid` repeats.
